fc_layer_sequencer: RTL and testbench
=====================================

# fc_layer_sequencer

Control sequencer for one fully-connected layer. It accepts the previous layer's outputs as a serial word stream over a valid/ready handshake and broadcasts each word to every neuron in the layer. It also drives the shared neuron control bus: the weight/bias ROM address, the accumulate strobe and the bias strobe. Once every neuron has accumulated the full vector, it signals downstream that the layer result is valid and holds that signal until it is accepted.

## Interface
- WORD_SIZE, 16, width of data words.
- PREVIOUS_LAYER_HEIGHT, 4, input vector length H (≥1); ROM addresses 0..H-1 hold weights, address H holds the bias.
- clk_i  input  1  rising-edge clock.
- reset_i  input  1  asynchronous, active-low reset.
- data_i  input  WORD_SIZE  signed input word x_k from the previous layer.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  sequencer accepts data_i this cycle.
- data_o  output  WORD_SIZE  registered word broadcast to the neurons.
- mem_addr_o  output  $clog2(H+1)  ROM address broadcast to the neurons.
- sum_en_o  output  1  neurons accumulate data_o × weight this cycle.
- add_bias_o  output  1  neurons load the bias into the accumulator this cycle (replaces prior contents).
- valid_o  output  1  neuron outputs hold the completed layer result.
- ready_i  input  1  downstream accepts the result.

## Operation
- One clock, clk_i; reset_i is asynchronous and active-low.
- States:
  - BIAS_ISSUE: mem_addr_o=H, ready_o=0. Goes unconditionally to ACCUM with k=0 and add_bias_o=1 registered for the next cycle.
  - ACCUM: mem_addr_o=k, ready_o=1. A transfer is valid_i&ready_o.
    - On a transfer: data_o<=data_i, sum_en_o<=1 for the next cycle, k<=k+1.
    - With no transfer: sum_en_o<=0 and k holds.
    - A transfer with k==H-1 goes to FLUSH.
  - FLUSH: ready_o=0, mem_addr_o=H. The last sum_en_o pulse is on the bus this cycle. Goes to OUT.
  - OUT: valid_o=1, ready_o=0, mem_addr_o=H.
    - valid_o&ready_i goes to BIAS_ISSUE.
    - Otherwise OUT holds, with valid_o held high and data_o stable.
- sum_en_o and add_bias_o are registered and are never high in the same cycle.
- Pulse counts per vector:
  - add_bias_o is high exactly 1 cycle.
  - sum_en_o is high exactly H cycles.
  - The bias pulse always precedes the first sum_en_o pulse.
- data_o changes only on ACCUM transfers and keeps its last value otherwise.
- Counter k is $clog2(H+1) bits and never exceeds H-1 in ACCUM. There is no wrap.
- There is no arithmetic in this block. Accumulation width and saturation belong to the neurons.

## Timing
- Reset asserted, asynchronously:
  - state=BIAS_ISSUE, k=0, mem_addr_o=H.
  - data_o=0, sum_en_o=0, add_bias_o=0, valid_o=0, ready_o=0.
- ROM alignment: mem_addr_o=a in cycle t means the ROM word a is valid in cycle t+1.
  - The matching data_o and strobe (sum_en_o or add_bias_o) are high in cycle t+1.
  - This one-cycle lag is mandatory.
- First cycle after reset release is BIAS_ISSUE; ACCUM begins the cycle after.
- With valid_i held high, the H transfers occur on H consecutive cycles.
- valid_o rises 2 cycles after the transfer cycle of x_{H-1}: one FLUSH cycle, plus one cycle for the neuron result register.
- Minimum cycles per vector with no stalls: H+3.
- The accept cycle of valid_o&ready_i is followed immediately by BIAS_ISSUE, so there is no idle cycle.
- ready_i is ignored outside OUT; valid_i is ignored when ready_o=0.
- Reset asserted mid-vector aborts the vector. No partial result is flagged valid.

## Test plan
- H=4, reset released, valid_i=1 continuously with x=1,2,3,4:
  - mem_addr_o sequence 4,0,1,2,3,4.
  - add_bias_o is 1 on the cycle after mem_addr_o=4.
  - sum_en_o is 1 for 4 consecutive cycles with data_o=1,2,3,4.
  - valid_o rises 2 cycles after x=4 is accepted.
- Same vector with valid_i low on alternate cycles:
  - exactly 4 sum_en_o pulses, each aligned 1 cycle after its transfer address.
  - data_o holds during bubbles.
  - sum_en_o is 0 on bubble+1 cycles.
- ready_i held 0 for 5 cycles in OUT, then 1:
  - valid_o stays 1 for 6 cycles, ready_o stays 0, no strobes fire.
  - The next cycle is BIAS_ISSUE with mem_addr_o=4.
- reset_i pulsed low after 2 transfers:
  - all outputs go to reset values immediately, without waiting for a clock edge.
  - After release, a fresh bias-first sequence starts and valid_o does not rise until 4 new transfers complete.
- Two back-to-back vectors with ready_i=1 throughout:
  - the period is H+3=7 cycles.
  - add_bias_o and sum_en_o are never high together.
- H=1 build, x=-5:
  - mem_addr_o 1,0.
  - one add_bias_o pulse, then one sum_en_o pulse with data_o=-5.
  - valid_o rises 2 cycles after the transfer.

Source files
------------

// File: rtl/fc_layer_sequencer_if.sv
// Bus bundle between the fully-connected layer sequencer, the previous layer,
// the neuron array and the downstream consumer.
interface fc_layer_sequencer_if #(
  parameter int unsigned WORD_SIZE             = 16,
  parameter int unsigned PREVIOUS_LAYER_HEIGHT = 4
);
  localparam int unsigned ADDR_W = $clog2(PREVIOUS_LAYER_HEIGHT + 1);

  // Input vector stream from the previous layer
  logic [WORD_SIZE-1:0] data_i;
  logic                 valid_i;
  logic                 ready_o;

  // Neuron control bus
  logic [WORD_SIZE-1:0] data_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic                 sum_en_o;
  logic                 add_bias_o;

  // Layer result handshake
  logic                 valid_o;
  logic                 ready_i;

  modport master (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, mem_addr_o, sum_en_o, add_bias_o, valid_o
  );

  modport slave (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, mem_addr_o, sum_en_o, add_bias_o, valid_o
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Control sequencer for one fully-connected layer: streams the input vector to
// the neurons, issues ROM addresses and bias/accumulate strobes, flags the result.
module fc_layer_sequencer #(
  parameter int unsigned WORD_SIZE             = 16,
  parameter int unsigned PREVIOUS_LAYER_HEIGHT = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  fc_layer_sequencer_if.master  bus
);
  localparam int unsigned H      = PREVIOUS_LAYER_HEIGHT;
  localparam int unsigned ADDR_W = $clog2(H + 1);

  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(H);
  localparam logic [ADDR_W-1:0] LAST_K    = ADDR_W'(H - 1);

  typedef enum logic [1:0] {
    BIAS_ISSUE = 2'd0,
    ACCUM      = 2'd1,
    FLUSH      = 2'd2,
    OUT        = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    k_q, k_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 sum_en_q, sum_en_d;
  logic                 add_bias_q, add_bias_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 xfer_c;

  // ready_q is high exactly while in ACCUM, so this is the accepted transfer
  assign xfer_c = bus.valid_i & ready_q;

  // State, counter and registered outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= BIAS_ISSUE;
      k_q        <= '0;
      data_q     <= '0;
      addr_q     <= BIAS_ADDR;
      sum_en_q   <= 1'b0;
      add_bias_q <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      sum_en_q   <= sum_en_d;
      add_bias_q <= add_bias_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
    end
  end

  // Next state; strobes are issued one cycle after their ROM address
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    data_d     = data_q;
    sum_en_d   = 1'b0;
    add_bias_d = 1'b0;

    case (state_q)
      BIAS_ISSUE: begin
        state_d    = ACCUM;
        k_d        = '0;
        add_bias_d = 1'b1;
      end
      ACCUM: begin
        if (xfer_c) begin
          data_d   = bus.data_i;
          sum_en_d = 1'b1;
          if (k_q == LAST_K) begin
            state_d = FLUSH;
            k_d     = '0;
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end
      end
      FLUSH: begin
        state_d = OUT;
      end
      OUT: begin
        if (bus.ready_i) begin
          state_d = BIAS_ISSUE;
        end
      end
      default: begin
        state_d = BIAS_ISSUE;
        k_d     = '0;
      end
    endcase

    // Decode the registered bus outputs from the state being entered
    ready_d = (state_d == ACCUM);
    valid_d = (state_d == OUT);
    addr_d  = (state_d == ACCUM) ? k_d : BIAS_ADDR;
  end

  assign bus.ready_o    = ready_q;
  assign bus.valid_o    = valid_q;
  assign bus.data_o     = data_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.sum_en_o   = sum_en_q;
  assign bus.add_bias_o = add_bias_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: an H=4 instance and an H=1 instance.
module tb_fc_layer_sequencer;
  logic clk;
  logic rst_n;
  logic rst1_n;
  int   errors;
  int   checks;

  fc_layer_sequencer_if #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4)) bus4 ();
  fc_layer_sequencer_if #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1)) bus1 ();

  fc_layer_sequencer #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(4)) dut4 (
    .clk_i  (clk),
    .reset_i(rst_n),
    .bus    (bus4)
  );

  fc_layer_sequencer #(.WORD_SIZE(16), .PREVIOUS_LAYER_HEIGHT(1)) dut1 (
    .clk_i  (clk),
    .reset_i(rst1_n),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation word: {addr, ready, bias, sum, valid, data}
  function automatic logic [22:0] snap4();
    return {bus4.mem_addr_o, bus4.ready_o, bus4.add_bias_o, bus4.sum_en_o,
            bus4.valid_o, bus4.data_o};
  endfunction

  function automatic logic [22:0] exp4(int a, int r, int b, int s, int v, int d);
    return {3'(a), 1'(r), 1'(b), 1'(s), 1'(v), 16'(d)};
  endfunction

  function automatic logic [20:0] snap1();
    return {bus1.mem_addr_o, bus1.ready_o, bus1.add_bias_o, bus1.sum_en_o,
            bus1.valid_o, bus1.data_o};
  endfunction

  function automatic logic [20:0] exp1(int a, int r, int b, int s, int v, int d);
    return {1'(a), 1'(r), 1'(b), 1'(s), 1'(v), 16'(d)};
  endfunction

  // Pulse the H=4 reset; returns just after release, inside cycle 0
  task automatic do_reset();
    @(negedge clk);
    bus4.valid_i = 1'b0;
    bus4.ready_i = 1'b0;
    bus4.data_i  = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    rst1_n = 1'b1;
    bus4.valid_i = 1'b0; bus4.ready_i = 1'b0; bus4.data_i = '0;
    bus1.valid_i = 1'b0; bus1.ready_i = 1'b0; bus1.data_i = '0;
    #2;
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (snap4() !== exp4(4, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_h4 n=%0d got=%h exp=%h", i, snap4(), exp4(4, 0, 0, 0, 0, 0));
      end
      checks++;
      if (snap1() !== exp1(1, 0, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset_h1 n=%0d got=%h exp=%h", i, snap1(), exp1(1, 0, 0, 0, 0, 0));
      end
    end
  endtask

  // valid_i held high, x=1..4, ready_i=1 throughout
  task automatic test_stream();
    int t [8][6] = '{
      '{4,0,0,0,0,0}, '{0,1,1,0,0,0}, '{1,1,0,1,0,1}, '{2,1,0,1,0,2},
      '{3,1,0,1,0,3}, '{4,0,0,1,0,4}, '{4,0,0,0,1,4}, '{4,0,0,0,0,4}};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if (snap4() !== exp4(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5])) begin
        errors++;
        $display("FAIL stream c=%0d got=%h exp=%h", c, snap4(),
                 exp4(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5]));
      end
      bus4.valid_i = 1'b1;
      bus4.ready_i = 1'b1;
      bus4.data_i  = (c >= 1 && c <= 4) ? 16'(c) : 16'h0;
    end
  endtask

  // valid_i low on alternate cycles; junk data on bubbles and during BIAS_ISSUE
  task automatic test_bubbles();
    int t [10][6] = '{
      '{4,0,0,0,0,0}, '{0,1,1,0,0,0}, '{1,1,0,1,0,1}, '{1,1,0,0,0,1},
      '{2,1,0,1,0,2}, '{2,1,0,0,0,2}, '{3,1,0,1,0,3}, '{3,1,0,0,0,3},
      '{4,0,0,1,0,4}, '{4,0,0,0,1,4}};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if (snap4() !== exp4(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5])) begin
        errors++;
        $display("FAIL bubbles c=%0d got=%h exp=%h", c, snap4(),
                 exp4(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5]));
      end
      bus4.ready_i = 1'b0;
      if (c == 0) begin
        bus4.valid_i = 1'b1; bus4.data_i = 16'h0063;
      end else if (c <= 7 && (c % 2) == 1) begin
        bus4.valid_i = 1'b1; bus4.data_i = 16'((c + 1) / 2);
      end else begin
        bus4.valid_i = 1'b0; bus4.data_i = 16'h0077;
      end
    end
  endtask

  // Downstream stalls OUT for 5 cycles, then accepts
  task automatic test_hold();
    int t [14][6] = '{
      '{4,0,0,0,0,0}, '{0,1,1,0,0,0}, '{1,1,0,1,0,1}, '{2,1,0,1,0,2},
      '{3,1,0,1,0,3}, '{4,0,0,1,0,4}, '{4,0,0,0,1,4}, '{4,0,0,0,1,4},
      '{4,0,0,0,1,4}, '{4,0,0,0,1,4}, '{4,0,0,0,1,4}, '{4,0,0,0,1,4},
      '{4,0,0,0,0,4}, '{0,1,1,0,0,4}};
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if (snap4() !== exp4(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5])) begin
        errors++;
        $display("FAIL hold c=%0d got=%h exp=%h", c, snap4(),
                 exp4(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5]));
      end
      bus4.valid_i = 1'b1;
      bus4.ready_i = (c == 11);
      bus4.data_i  = (c >= 1 && c <= 4) ? 16'(c) : 16'h0055;
    end
  endtask

  // Asynchronous reset after two transfers, then a complete fresh vector
  task automatic test_reset_mid();
    int nsum;
    int nbias;
    int bias_c;
    int first_sum_c;
    nsum = 0; nbias = 0; bias_c = -1; first_sum_c = -1;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      bus4.valid_i = 1'b1;
      bus4.data_i  = 16'(c);
    end
    @(negedge clk); #1;
    checks++;
    if (snap4() !== exp4(2, 1, 0, 1, 0, 2)) begin
      errors++;
      $display("FAIL mid_pre got=%h exp=%h", snap4(), exp4(2, 1, 0, 1, 0, 2));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (snap4() !== exp4(4, 0, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL mid_async got=%h exp=%h", snap4(), exp4(4, 0, 0, 0, 0, 0));
    end
    #1;
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (bus4.add_bias_o === 1'b1) begin nbias++; bias_c = c; end
      if (bus4.sum_en_o === 1'b1) begin
        if (first_sum_c < 0) first_sum_c = c;
        nsum++;
      end
      checks++;
      if (bus4.valid_o !== (c == 6)) begin
        errors++;
        $display("FAIL mid_valid c=%0d got=%b exp=%b", c, bus4.valid_o, (c == 6));
      end
      bus4.valid_i = 1'b1;
      bus4.data_i  = (c >= 1 && c <= 4) ? 16'(c + 4) : 16'h0;
    end
    checks++;
    if (nsum != 4 || nbias != 1 || bias_c != 1 || first_sum_c != 2) begin
      errors++;
      $display("FAIL mid_pulses got sum=%0d bias=%0d bias_c=%0d sum_c=%0d exp 4 1 1 2",
               nsum, nbias, bias_c, first_sum_c);
    end
    checks++;
    if (bus4.data_o !== 16'd8) begin
      errors++;
      $display("FAIL mid_data got=%0d exp=8", bus4.data_o);
    end
  endtask

  // Two vectors with valid_i and ready_i high throughout
  task automatic test_back_to_back();
    logic [15:0] xs [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd10, 16'd11, 16'd12};
    int idx;
    int nsum;
    int bias_at [2];
    int val_at [2];
    int nb;
    int nv;
    idx = 0; nsum = 0; nb = 0; nv = 0;
    bias_at = '{-1, -1};
    val_at  = '{-1, -1};
    do_reset();
    for (int c = 0; c < 15; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if ((bus4.add_bias_o & bus4.sum_en_o) !== 1'b0) begin
        errors++;
        $display("FAIL b2b_overlap c=%0d got bias=%b sum=%b exp not both",
                 c, bus4.add_bias_o, bus4.sum_en_o);
      end
      if (bus4.add_bias_o === 1'b1 && nb < 2) begin bias_at[nb] = c; nb++; end
      if (bus4.valid_o === 1'b1 && nv < 2 && (nv == 0 || val_at[0] != c - 1)) begin
        val_at[nv] = c; nv++;
      end
      if (bus4.sum_en_o === 1'b1 && nsum < 8) begin
        checks++;
        if (bus4.data_o !== xs[nsum]) begin
          errors++;
          $display("FAIL b2b_data n=%0d got=%0d exp=%0d", nsum, bus4.data_o, xs[nsum]);
        end
        nsum++;
      end
      bus4.valid_i = 1'b1;
      bus4.ready_i = 1'b1;
      if (bus4.ready_o === 1'b1 && idx < 8) begin
        bus4.data_i = xs[idx];
        idx++;
      end else begin
        bus4.data_i = 16'h0;
      end
    end
    checks++;
    if (bias_at[0] != 1 || bias_at[1] != 8) begin
      errors++;
      $display("FAIL b2b_period got bias at %0d,%0d exp 1,8", bias_at[0], bias_at[1]);
    end
    checks++;
    if (val_at[0] != 6 || val_at[1] != 13 || nsum != 8) begin
      errors++;
      $display("FAIL b2b_valid got valid at %0d,%0d sums=%0d exp 6,13 sums=8",
               val_at[0], val_at[1], nsum);
    end
  endtask

  // H=1 instance with x=-5
  task automatic test_h1();
    int t [5][6] = '{
      '{1,0,0,0,0,0}, '{0,1,1,0,0,0}, '{1,0,0,1,0,-5}, '{1,0,0,0,1,-5}, '{1,0,0,0,1,-5}};
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      checks++;
      if (snap1() !== exp1(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5])) begin
        errors++;
        $display("FAIL h1 c=%0d got=%h exp=%h", c, snap1(),
                 exp1(t[c][0], t[c][1], t[c][2], t[c][3], t[c][4], t[c][5]));
      end
      bus1.valid_i = 1'b1;
      bus1.ready_i = 1'b0;
      bus1.data_i  = 16'hFFFB;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stream();
    test_bubbles();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_h1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
